// File: rtl/conv_apb_pkg.sv
// Shared definitions for the conv accelerator APB initiator.
// State encoding and conv register map offsets.
package conv_apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam logic [31:0] CONV_START_OFFS = 32'h0000_0000;
  localparam logic [31:0] CONV_DONE_OFFS  = 32'h0000_0004;
  localparam logic [31:0] CLK_COUNT_OFFS  = 32'h0000_0008;

endpackage

// File: rtl/conv_apb_master.sv
// APB initiator for the conv accelerator: single write, read or
// poll-read per request, one transaction outstanding.
module conv_apb_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_LIMIT = 1000
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_poll,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [15:0]           rsp_reads,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);
  import conv_apb_pkg::*;

  localparam logic [15:0] LIMIT = 16'(POLL_LIMIT);

  apb_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic                  write_q;
  logic                  poll_q;
  logic [15:0]           cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  tmo_q;

  logic                  accept;
  logic                  done;
  logic                  hit;
  logic [15:0]           cnt_inc;
  logic                  at_limit;
  logic                  retry;
  logic                  tmo;

  assign accept   = req_valid & req_ready;
  assign done     = (state_q == ACCESS) & PREADY;
  assign hit      = ((PRDATA ^ wdata_q) & mask_q) == '0;
  assign cnt_inc  = cnt_q + 16'd1;
  assign at_limit = cnt_inc >= LIMIT;
  assign retry    = poll_q & ~PSLVERR & ~hit & ~at_limit;
  assign tmo      = poll_q & ~PSLVERR & ~hit & at_limit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (PREADY) state_d = retry ? SETUP : RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
      poll_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mask_q  <= req_mask;
        write_q <= req_write & ~req_poll;
        poll_q  <= req_poll;
        cnt_q   <= '0;
      end
      if (done) begin
        rdata_q <= write_q ? '0 : PRDATA;
        cnt_q   <= cnt_inc;
        err_q   <= PSLVERR | tmo;
        tmo_q   <= tmo;
      end
    end
  end

  // Bus controls decode straight from state so reset drops them at once
  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign PSEL        = (state_q == SETUP) | (state_q == ACCESS);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = addr_q;
  assign PWRITE      = write_q;
  assign PWDATA      = wdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign rsp_reads   = cnt_q;

endmodule
